pulldown_scan_ctrl: RTL and testbench

- Time-multiplexes pull-down emulation across BANKS banks of WIDTH tri-state input pins.
- Per bank: drives the pins low, releases them, waits for settling, then samples. Advances round-robin through the banks.
- Debounces each sampled pin over consecutive scans and presents a stable pin image to user logic.
- Sits between the IO-board pad tri-state buffers (top level) and button/DIP consumer logic.

---
 rtl/pulldown_scan_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pulldown_scan_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pulldown_scan_ctrl.sv
// Round-robin pull-down emulation for banks of tri-state pads: pull low, release,
// settle, sample, then debounce every pin into a stable image for user logic.
module pulldown_scan_ctrl #(
    parameter int BANKS         = 4,
    parameter int WIDTH         = 8,
    parameter int PULL_CYCLES   = 1,
    parameter int SETTLE_CYCLES = 3,
    parameter int DEBOUNCE      = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   enable,
    input  logic [BANKS*WIDTH-1:0]                 pins_in,
    output logic [BANKS*WIDTH-1:0]                 drive_low,
    output logic [BANKS*WIDTH-1:0]                 state_out,
    output logic [((BANKS>1)?$clog2(BANKS):1)-1:0] bank_idx,
    output logic                                   scan_done,
    output logic                                   changed
);
    localparam int N        = BANKS * WIDTH;
    localparam int BW       = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int MAXP     = (PULL_CYCLES > SETTLE_CYCLES) ? PULL_CYCLES : SETTLE_CYCLES;
    localparam int PW       = $clog2(MAXP + 1);
    localparam int CW       = $clog2(DEBOUNCE + 1);
    localparam int SET_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PULL   = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_SAMPLE = 2'd3;

    logic [1:0]            r_state;
    logic [PW-1:0]         r_phase;
    logic [BW-1:0]         r_bank;
    logic [N-1:0]          r_drive;
    logic [N-1:0]          r_state_out;
    logic [N-1:0]          r_last;
    logic [N-1:0][CW-1:0]  r_cnt;
    logic                  r_scan_done;
    logic                  r_changed;
    logic                  r_acc;

    logic                  w_sample;
    logic                  w_last_bank;
    logic [N-1:0]          w_sel;
    logic [N-1:0][CW-1:0]  w_cnt_nxt;
    logic [N-1:0]          w_st_nxt;
    logic [N-1:0]          w_pin_chg;
    logic                  w_chg_any;

    function automatic logic [N-1:0] f_mask(input logic [BW-1:0] b);
        f_mask = '0;
        for (int k = 0; k < BANKS; k++)
            if (int'(b) == k) f_mask[k*WIDTH +: WIDTH] = '1;
    endfunction

    // An abort in the SAMPLE cycle suppresses the capture.
    assign w_sample    = (r_state == S_SAMPLE) && enable;
    assign w_last_bank = (r_bank == BW'(BANKS - 1));

    always_comb begin
        w_sel     = f_mask(r_bank) & {N{w_sample}};
        w_cnt_nxt = r_cnt;
        w_st_nxt  = r_state_out;
        for (int p = 0; p < N; p++) begin
            if (pins_in[p] != r_last[p])
                w_cnt_nxt[p] = CW'(1);
            else if (r_cnt[p] != CW'(DEBOUNCE))
                w_cnt_nxt[p] = r_cnt[p] + CW'(1);
            if (w_cnt_nxt[p] >= CW'(DEBOUNCE))
                w_st_nxt[p] = pins_in[p];
        end
        w_pin_chg = w_sel & (w_st_nxt ^ r_state_out);
        w_chg_any = |w_pin_chg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= '0;
            r_cnt       <= '0;
            r_state_out <= '0;
        end else begin
            for (int p = 0; p < N; p++) begin
                if (w_sel[p]) begin
                    r_last[p]      <= pins_in[p];
                    r_cnt[p]       <= w_cnt_nxt[p];
                    r_state_out[p] <= w_st_nxt[p];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_bank      <= '0;
            r_drive     <= '0;
            r_scan_done <= 1'b0;
            r_changed   <= 1'b0;
            r_acc       <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            r_changed   <= 1'b0;
            if (r_state != S_IDLE && !enable) begin
                r_state <= S_IDLE;
                r_phase <= '0;
                r_bank  <= '0;
                r_drive <= '0;
                r_acc   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (enable) begin
                            r_state <= S_PULL;
                            r_phase <= '0;
                            r_bank  <= '0;
                            r_drive <= f_mask('0);
                        end
                    end
                    S_PULL: begin
                        if (r_phase == PW'(PULL_CYCLES - 1)) begin
                            r_phase <= '0;
                            r_drive <= '0;
                            r_state <= (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
                        end else begin
                            r_phase <= r_phase + PW'(1);
                        end
                    end
                    S_SETTLE: begin
                        if (r_phase == PW'(SET_LAST)) begin
                            r_phase <= '0;
                            r_state <= S_SAMPLE;
                        end else begin
                            r_phase <= r_phase + PW'(1);
                        end
                    end
                    default: begin
                        r_phase <= '0;
                        r_state <= S_PULL;
                        if (w_last_bank) begin
                            // Changes from the final bank land in this scan's pulse.
                            r_bank      <= '0;
                            r_drive     <= f_mask('0);
                            r_scan_done <= 1'b1;
                            r_changed   <= r_acc | w_chg_any;
                            r_acc       <= 1'b0;
                        end else begin
                            r_bank  <= r_bank + BW'(1);
                            r_drive <= f_mask(r_bank + BW'(1));
                            r_acc   <= r_acc | w_chg_any;
                        end
                    end
                endcase
            end
        end
    end

    assign drive_low = r_drive;
    assign state_out = r_state_out;
    assign bank_idx  = r_bank;
    assign scan_done = r_scan_done;
    assign changed   = r_changed;
endmodule

// File: tb/tb_pulldown_scan_ctrl.sv
// Bench for pulldown_scan_ctrl: a time-indexed scan model checks a default-parameter
// instance and a single-bank, no-settle instance every cycle, plus pinned literals.
module tb_pulldown_scan_ctrl;
    localparam int W   = 8;
    localparam int DEB = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [31:0] pins = '1;
    logic [31:0] dl1, so1;
    logic [1:0]  bi1;
    logic        sd1, ch1;
    logic [7:0]  dl2, so2;
    logic        bi2;
    logic        sd2, ch2;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_on = 1'b0;
    logic [31:0] so_snap;

    always #5 clk = ~clk;

    pulldown_scan_ctrl u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en), .pins_in(pins),
        .drive_low(dl1), .state_out(so1), .bank_idx(bi1),
        .scan_done(sd1), .changed(ch1)
    );

    pulldown_scan_ctrl #(
        .BANKS(1), .WIDTH(8), .PULL_CYCLES(2), .SETTLE_CYCLES(0), .DEBOUNCE(2)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .enable(en), .pins_in(pins[7:0]),
        .drive_low(dl2), .state_out(so2), .bank_idx(bi2),
        .scan_done(sd2), .changed(ch2)
    );

    // Model: position in a scan is a cycle index; bank and phase follow by division.
    int          NB[2]  = '{4, 1};
    int          PL[2]  = '{1, 2};
    int          STL[2] = '{3, 0};
    bit          m_run[2];
    int          m_t[2];
    bit          m_last[2][32];
    int          m_cnt[2][32];
    logic [31:0] m_st[2];
    bit          m_acc[2];
    logic [31:0] e_dl[2];
    int          e_bank[2];
    bit          e_sd[2];
    bit          e_ch[2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_run[m] = 0; m_t[m] = 0; m_acc[m] = 0; m_st[m] = '0;
            e_dl[m] = '0; e_bank[m] = 0; e_sd[m] = 0; e_ch[m] = 0;
            for (int p = 0; p < 32; p++) begin
                m_last[m][p] = 0; m_cnt[m][p] = 0;
            end
        end
    endtask

    task automatic model_step(input int m, input bit e, input logic [31:0] pv);
        int P, S, bk;
        P = PL[m] + STL[m] + 1;
        S = P * NB[m];
        e_sd[m] = 0;
        e_ch[m] = 0;
        if (!m_run[m]) begin
            if (e) begin m_run[m] = 1; m_t[m] = 0; end
        end else if (!e) begin
            m_run[m] = 0;
            m_acc[m] = 0;
        end else begin
            bk = m_t[m] / P;
            if (m_t[m] % P == P - 1) begin
                for (int w = 0; w < W; w++) begin
                    int p;
                    p = bk * W + w;
                    if (pv[p] == m_last[m][p]) m_cnt[m][p] = (m_cnt[m][p] + 1 > DEB) ? DEB : m_cnt[m][p] + 1;
                    else begin m_cnt[m][p] = 1; m_last[m][p] = pv[p]; end
                    if (m_cnt[m][p] >= DEB && m_st[m][p] != pv[p]) begin
                        m_st[m][p] = pv[p];
                        m_acc[m] = 1;
                    end
                end
            end
            m_t[m] = (m_t[m] + 1) % S;
            if (m_t[m] == 0) begin
                e_sd[m] = 1;
                e_ch[m] = m_acc[m];
                m_acc[m] = 0;
            end
        end
        e_dl[m] = '0;
        e_bank[m] = 0;
        if (m_run[m]) begin
            bk = m_t[m] / P;
            e_bank[m] = bk;
            if (m_t[m] % P < PL[m]) e_dl[m][bk*W +: W] = 8'hFF;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else begin
            model_step(0, en, pins);
            model_step(1, en, {24'h0, pins[7:0]});
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("dut1_drive_low", dl1, e_dl[0]);
            chk("dut1_state_out", so1, m_st[0]);
            chk("dut1_bank_idx", 32'(bi1), e_bank[0]);
            chk("dut1_scan_done", 32'(sd1), 32'(e_sd[0]));
            chk("dut1_changed", 32'(ch1), 32'(e_ch[0]));
            chk("dut2_drive_low", 32'(dl2), e_dl[1]);
            chk("dut2_state_out", 32'(so2), m_st[1]);
            chk("dut2_bank_idx", 32'(bi2), e_bank[1]);
            chk("dut2_scan_done", 32'(sd2), 32'(e_sd[1]));
            chk("dut2_changed", 32'(ch2), 32'(e_ch[1]));
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_drive", dl1, 32'h0);
        chk("idle_state", so1, 32'h0);
        chk("idle_done", 32'(sd1), 32'h0);

        // Basic scan, all pins low.
        pins = '0; en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0)  begin chk("A_dl_c0", dl1, 32'h0000_00FF); chk("B1_dl_c0", 32'(dl2), 32'hFF); end
            if (c == 1)  begin chk("A_dl_c1", dl1, 32'h0); chk("B1_dl_c1", 32'(dl2), 32'hFF); end
            if (c == 2)  chk("B1_dl_c2", 32'(dl2), 32'h0);
            if (c == 3)  chk("B1_done_c3", 32'(sd2), 32'h1);
            if (c == 5)  begin chk("A_dl_c5", dl1, 32'h0000_FF00); chk("A_bank_c5", 32'(bi1), 32'd1); end
            if (c == 10) chk("A_dl_c10", dl1, 32'h00FF_0000);
            if (c == 19) chk("A_done_c19", 32'(sd1), 32'h0);
            if (c == 20) begin chk("A_done_c20", 32'(sd1), 32'h1); chk("A_bank_c20", 32'(bi1), 32'd0); end
        end

        // Bit 19 held high: qualifies on the second scan.
        en = 1'b0;
        @(negedge clk);
        pins = 32'h0008_0000; en = 1'b1;
        for (int c = 0; c <= 60; c++) begin
            @(negedge clk);
            if (c == 20) begin chk("B_s19_scan1", 32'(so1[19]), 32'h0); chk("B_ch_scan1", 32'(ch1), 32'h0); end
            if (c == 34) chk("B_s19_c34", 32'(so1[19]), 32'h0);
            if (c == 35) chk("B_s19_c35", 32'(so1[19]), 32'h1);
            if (c == 40) begin chk("B_ch_scan2", 32'(ch1), 32'h1); chk("B_done_scan2", 32'(sd1), 32'h1); end
            if (c == 60) begin chk("B_ch_scan3", 32'(ch1), 32'h0); chk("B_done_scan3", 32'(sd1), 32'h1); end
        end

        // Drop back to 0, then a one-scan glitch that must not qualify.
        en = 1'b0;
        @(negedge clk);
        pins = '0; en = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == 40) chk("C_ch_fall", 32'(ch1), 32'h1);
            if (c == 60) chk("C_ch_glitch1", 32'(ch1), 32'h0);
            if (c == 80) chk("C_ch_glitch2", 32'(ch1), 32'h0);
            if (c >= 36 && c % 4 == 0) chk("C_s19_low", 32'(so1[19]), 32'h0);
            if (c == 39) pins = 32'h0008_0000;
            if (c == 59) pins = '0;
        end

        // Abort in the second settle cycle of bank 1.
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        for (int c = 0; c < 21; c++) begin
            @(negedge clk);
            if (c == 7) begin
                chk("D_bank_c7", 32'(bi1), 32'd1);
                so_snap = so1;
                en = 1'b0;
            end
            if (c == 8) begin
                chk("D_abort_dl", dl1, 32'h0);
                chk("D_abort_bank", 32'(bi1), 32'd0);
                chk("D_abort_done", 32'(sd1), 32'h0);
                chk("D_abort_state", so1, so_snap);
                en = 1'b1;
            end
            if (c == 9) begin
                chk("D_restart_dl", dl1, 32'h0000_00FF);
                chk("D_restart_bank", 32'(bi1), 32'd0);
            end
        end

        // Random pins with occasional aborts.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(63) == 0) pins = $urandom;
            en = ($urandom_range(99) != 0);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
